// File: rtl/tmr_pkg.sv
// tmr_pkg: shared lane, mask and FSM types for the TMR repair scheduler
package tmr_pkg;
  localparam int N_TMR = 3;
  typedef logic [1:0] lane_t;
  typedef logic [N_TMR-1:0] mask_t;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SETTLE, CHECK} state_t;
  function automatic lane_t nxt(input lane_t l);
    return l == 2'd2 ? 2'd0 : l + 2'd1;
  endfunction
endpackage

// File: rtl/tmr_repair_sched_rr_pick3.sv
// rr_pick3: first set lane of a 3-bit mask searching from ptr, wrapping 2->0
module rr_pick3
  import tmr_pkg::*;
(
  input  mask_t      mask,
  input  lane_t      ptr,
  output lane_t      idx,
  output logic       valid
);
  logic [3:0] m;
  lane_t p1, p2;
  always_comb begin
    m = {1'b0, mask};
    p1 = nxt(ptr);
    p2 = nxt(p1);
    idx = m[ptr] ? ptr : m[p1] ? p1 : p2;
    valid = |mask;
  end
endmodule

// File: rtl/tmr_repair_sched.sv
// tmr_repair_sched: round-robin scrub/reload scheduler for disabled TMR lanes
module tmr_repair_sched
  import tmr_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_RETRY     = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dis_req,
  input  logic        hold,
  input  logic        dead_clr,
  output logic        scrub_req,
  output logic [1:0]  scrub_lane,
  input  logic        scrub_ack,
  input  logic        scrub_done,
  input  logic        scrub_pass,
  output logic [2:0]  repaired,
  output logic [2:0]  dead,
  output logic        busy
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_t state, state_n;
  lane_t lane, rr, pick;
  logic pick_v, ok, gone, drop, launch, settle_end, time_out;
  logic [RW-1:0] retry [N_TMR];
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [3:0] dis4;
  mask_t pending;
  rr_pick3 u_pick (.mask(pending), .ptr(rr), .idx(pick), .valid(pick_v));
  always_comb begin
    pending = dis_req & ~dead;
    dis4 = {1'b0, dis_req};
    drop = gone | ~dis4[lane];
    launch = state == IDLE && pick_v && !hold && !dead_clr;
    settle_end = state == SETTLE && int'(scnt) == SETTLE_CYCLES - 1;
    time_out = state == WAIT && !scrub_done && int'(tcnt) == TIMEOUT - 2;
    scrub_req = state == REQ;
    scrub_lane = lane;
    busy = state != IDLE;
    repaired = (state == CHECK && ok && !drop) ? mask_t'(1) << lane : '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = launch ? REQ : IDLE;
      REQ:     state_n = !scrub_ack ? REQ : scrub_done ? SETTLE : WAIT;
      WAIT:    state_n = scrub_done ? SETTLE : time_out ? CHECK : WAIT;
      SETTLE:  state_n = settle_end ? CHECK : SETTLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
      rr <= '0;
      tcnt <= '0;
      scnt <= '0;
      ok <= 1'b0;
      gone <= 1'b0;
      dead <= '0;
      retry <= '{default: '0};
    end else begin
      lane <= launch ? pick : lane;
      gone <= launch ? 1'b0 : drop;
      tcnt <= state == REQ ? '0 : state == WAIT ? tcnt + 1'b1 : tcnt;
      scnt <= state == SETTLE ? scnt + 1'b1 : '0;
      ok <= settle_end ? scrub_pass : time_out ? 1'b0 : ok;
      rr <= state == CHECK ? nxt(lane) : rr;
      // a clear in the CHECK cycle overrides that cycle's retry/dead update
      if (dead_clr) begin
        dead <= '0;
        retry <= '{default: '0};
      end else if (state == CHECK) begin
        if (drop || ok) retry[lane] <= '0;
        else if (int'(retry[lane]) < MAX_RETRY) begin
          retry[lane] <= retry[lane] + 1'b1;
          if (int'(retry[lane]) == MAX_RETRY - 1) dead[lane] <= 1'b1;
        end
      end
    end
  end
endmodule
